// File: rtl/nbody_fx_pkg.sv
// Fixed-point types and helpers shared by the Verlet collector and its lanes.
// Latency: none (types, constants, combinational functions only).
// Backpressure: n/a. Build option NBODY_SAT_EN makes fx_reduce saturate instead of wrap.
package nbody_fx_pkg;

    localparam int W    = 32;
    localparam int FRAC = 16;

    typedef logic signed [W-1:0] fx_t;

    localparam fx_t FX_ONE = 32'sh0001_0000;
    localparam fx_t FX_MAX = 32'sh7FFF_FFFF;
    localparam fx_t FX_MIN = 32'sh8000_0000;

    typedef enum logic [1:0] {
        ST_ACCUM  = 2'd0,
        ST_MUL    = 2'd1,
        ST_UPDATE = 2'd2,
        ST_HOLD   = 2'd3
    } coll_state_e;

    // Narrow a sign-extended 2W value to W bits: clamp or two's-complement wrap.
    function automatic fx_t fx_reduce(input logic signed [2*W-1:0] v);
`ifdef NBODY_SAT_EN
        if (v > $signed({{W{1'b0}}, FX_MAX})) return FX_MAX;
        if (v < $signed({{W{1'b1}}, FX_MIN})) return FX_MIN;
`endif
        return v[W-1:0];
    endfunction

    // Fixed-point multiply: full 2W product, floor shift by FRAC, then reduce.
    function automatic fx_t fx_mul(input fx_t a, input fx_t b);
        logic signed [2*W-1:0] ax;
        logic signed [2*W-1:0] bx;
        logic signed [2*W-1:0] p;
        ax = {{W{a[W-1]}}, a};
        bx = {{W{b[W-1]}}, b};
        p  = ax * bx;
        return fx_reduce(p >>> FRAC);
    endfunction

endpackage

// File: rtl/nbody_verlet_lane.sv
// One lane: force accumulation over N_BLOCKS beats, scale by k, Verlet position update.
// Latency: MUL and UPDATE take one cycle each; results are registered at the end of UPDATE.
// Backpressure: none internally; the top gates accum_en and drops beats once the lane is full (ovr).
import nbody_fx_pkg::*;

module nbody_verlet_lane #(
    parameter int N_BLOCKS = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic accum_en,
    input  logic sample,
    input  logic mul_en,
    input  logic upd_en,
    input  logic clr,
    input  logic in_vld,
    input  fx_t  in_dat,
    input  fx_t  q_t,
    input  fx_t  q_told,
    input  fx_t  k,
    output logic full_d,
    output logic ovr,
    output fx_t  out_q_t,
    output fx_t  out_q_told
);

    // Headroom so N_BLOCKS full-scale beats can never wrap before reduction.
    localparam int AW = W + $clog2(N_BLOCKS) + 1;
    localparam int CW = $clog2(N_BLOCKS + 1);

    logic signed [AW-1:0]  acc_q, acc_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    fx_t                   qt_q, qo_q, prod_q, oqt_q, oqo_q;
    logic signed [2*W-1:0] acc_x;
    logic signed [W+1:0]   qt_x, qo_x, pr_x, qn_w;
    logic signed [2*W-1:0] qn_x;

    // Next accumulator/counter: clear on handshake, add accepted beats, flag beats past full.
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        ovr   = 1'b0;
        if (clr) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (accum_en && in_vld) begin
            if (cnt_q == CW'(N_BLOCKS)) begin
                ovr = 1'b1;
            end else begin
                acc_d = acc_q + {{(AW-W){in_dat[W-1]}}, in_dat};
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    assign full_d = (cnt_d == CW'(N_BLOCKS));

    // Sign-extended operands for the reduction and the W+2 bit position update.
    always_comb begin
        acc_x = {{(2*W-AW){acc_q[AW-1]}}, acc_q};
        qt_x  = {{2{qt_q[W-1]}}, qt_q};
        qo_x  = {{2{qo_q[W-1]}}, qo_q};
        pr_x  = {{2{prod_q[W-1]}}, prod_q};
        qn_w  = (qt_x <<< 1) - qo_x + pr_x;
        qn_x  = {{(W-2){qn_w[W+1]}}, qn_w};
    end

    // Accumulator and beat counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    // Position sample, scaled force, and registered update results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            qt_q   <= '0;
            qo_q   <= '0;
            prod_q <= '0;
            oqt_q  <= '0;
            oqo_q  <= '0;
        end else begin
            if (sample) begin
                qt_q <= q_t;
                qo_q <= q_told;
            end
            if (mul_en) prod_q <= fx_mul(fx_reduce(acc_x), k);
            if (upd_en) begin
                oqt_q <= fx_reduce(qn_x);
                oqo_q <= qt_q;
            end
        end
    end

    assign out_q_t    = oqt_q;
    assign out_q_told = oqo_q;

endmodule

// File: rtl/nbody_verlet_collector.sv
// Collects skewed per-row force sums, scales by G*dt^2 and does the Verlet update per block-row.
// Latency: final lane beat in cycle T gives out_valid in cycle T+3 (ACCUM->MUL->UPDATE->HOLD).
// Backpressure: in_ready only in ACCUM; HOLD keeps outputs stable until out_ready. Option: NBODY_SAT_EN.
import nbody_fx_pkg::*;

module nbody_verlet_collector #(
    parameter int N_ROWS      = 2,
    parameter int N_BLOCKS    = 2,
    parameter int N_BODY_ROWS = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_ROWS-1:0]              in_valid,
    input  logic [N_ROWS*W-1:0]            in_force,
    output logic                           in_ready,
    input  logic [N_ROWS*W-1:0]            in_q_t,
    input  logic [N_ROWS*W-1:0]            in_q_told,
    input  logic [W-1:0]                   cfg_k,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [N_ROWS*W-1:0]            out_q_t,
    output logic [N_ROWS*W-1:0]            out_q_told,
    output logic [$clog2(N_BODY_ROWS)-1:0] out_row,
    output logic                           out_step_done
);

    localparam int RW = $clog2(N_BODY_ROWS);

    coll_state_e   state_q, state_d;
    logic [RW-1:0] row_q, row_d;
    fx_t           k_q;
    logic          err_overrun_q;
    logic          go, hs, row_last;
    logic [N_ROWS-1:0] lane_full, lane_ovr;

    assign row_last = (row_q == RW'(N_BODY_ROWS - 1));

    // Shared FSM: next state and handshake-side outputs.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        go        = 1'b0;
        hs        = 1'b0;
        case (state_q)
            ST_ACCUM: begin
                in_ready = ~rst;
                if (&lane_full) begin
                    go      = 1'b1;
                    state_d = ST_MUL;
                end
            end
            ST_MUL:    state_d = ST_UPDATE;
            ST_UPDATE: state_d = ST_HOLD;
            ST_HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    hs      = 1'b1;
                    state_d = ST_ACCUM;
                end
            end
            default:   state_d = ST_ACCUM;
        endcase
    end

    // Block-row index advances on every output handshake and wraps per timestep.
    always_comb begin
        row_d = row_q;
        if (hs) row_d = row_last ? '0 : row_q + RW'(1);
    end

    // State, row index, sampled scale factor and sticky overrun flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_ACCUM;
            row_q         <= '0;
            k_q           <= '0;
            err_overrun_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            if (go) k_q   <= cfg_k;
            err_overrun_q <= err_overrun_q | (|lane_ovr);
        end
    end

    assign out_row       = row_q;
    assign out_step_done = hs & row_last;

    for (genvar r = 0; r < N_ROWS; r++) begin : g_lane
        nbody_verlet_lane #(.N_BLOCKS(N_BLOCKS)) u_lane (
            .clk        (clk),
            .rst        (rst),
            .accum_en   (in_ready),
            .sample     (go),
            .mul_en     (state_q == ST_MUL),
            .upd_en     (state_q == ST_UPDATE),
            .clr        (hs),
            .in_vld     (in_valid[r]),
            .in_dat     (in_force[r*W +: W]),
            .q_t        (in_q_t[r*W +: W]),
            .q_told     (in_q_told[r*W +: W]),
            .k          (k_q),
            .full_d     (lane_full[r]),
            .ovr        (lane_ovr[r]),
            .out_q_t    (out_q_t[r*W +: W]),
            .out_q_told (out_q_told[r*W +: W])
        );
    end

endmodule

// File: tb/tb_nbody_verlet_collector.sv
// Directed + randomized bench for nbody_verlet_collector against an arithmetic reference model.
// Latency: checks out_valid exactly three cycles after the last accepted beat.
// Backpressure: exercises out_ready stalls with ignored input beats.
import nbody_fx_pkg::*;

module tb_nbody_verlet_collector;

    localparam int NR  = 2;
    localparam int NB  = 2;
    localparam int NBR = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic [NR-1:0]      in_valid;
    logic [NR*W-1:0]    in_force;
    logic               in_ready;
    logic [NR*W-1:0]    in_q_t;
    logic [NR*W-1:0]    in_q_told;
    logic [W-1:0]       cfg_k;
    logic               out_valid;
    logic               out_ready;
    logic [NR*W-1:0]    out_q_t;
    logic [NR*W-1:0]    out_q_told;
    logic [$clog2(NBR)-1:0] out_row;
    logic               out_step_done;

    int  total = 0;
    int  bad   = 0;
    fx_t f  [NR][NB];
    fx_t qt [NR];
    fx_t qo [NR];
    fx_t kv;
    int  row_m;

    nbody_verlet_collector #(.N_ROWS(NR), .N_BLOCKS(NB), .N_BODY_ROWS(NBR)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_force(in_force), .in_ready(in_ready),
        .in_q_t(in_q_t), .in_q_told(in_q_told), .cfg_k(cfg_k), .out_valid(out_valid),
        .out_ready(out_ready), .out_q_t(out_q_t), .out_q_told(out_q_told), .out_row(out_row),
        .out_step_done(out_step_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Reduction of an exact integer to W bits, as the chosen build defines it.
    function automatic longint red(input longint v);
        logic signed [31:0] t;
`ifdef NBODY_SAT_EN
        if (v > 64'sd2147483647) return 64'sd2147483647;
        if (v < -64'sd2147483648) return -64'sd2147483648;
`endif
        t = v[31:0];
        return longint'(t);
    endfunction

    // Expected new position of lane r from the exact sum of its beats.
    function automatic logic [31:0] model_q(input int r);
        longint s, p, q;
        s = 0;
        for (int b = 0; b < NB; b++) s += longint'(f[r][b]);
        s = red(s);
        p = red((s * longint'(kv)) >>> FRAC);
        q = red(2 * longint'(qt[r]) - longint'(qo[r]) + p);
        return q[31:0];
    endfunction

    task automatic apply_q();
        for (int r = 0; r < NR; r++) begin
            in_q_t[r*W +: W]    = qt[r];
            in_q_told[r*W +: W] = qo[r];
        end
        cfg_k = kv;
    endtask

    task automatic rand_row(input bit full_range);
        for (int r = 0; r < NR; r++) begin
            for (int b = 0; b < NB; b++)
                f[r][b] = full_range ? $urandom : $urandom_range(0, 32'h000F_FFFF) - 32'h0008_0000;
            qt[r] = $urandom_range(0, 32'h01FF_FFFF) - 32'h0100_0000;
            qo[r] = $urandom_range(0, 32'h01FF_FFFF) - 32'h0100_0000;
        end
        kv = $urandom_range(0, 32'h0002_0000);
    endtask

    task automatic chk_outputs(input string tag);
        for (int r = 0; r < NR; r++) begin
            chk($sformatf("%s q_t[%0d]", tag, r), out_q_t[r*W +: W], model_q(r));
            chk($sformatf("%s q_told[%0d]", tag, r), out_q_told[r*W +: W], qt[r]);
        end
        chk({tag, " row"}, 32'(out_row), 32'(row_m));
    endtask

    // Lane0 sends NB+extra0 beats from cycle 0, lane1 sends NB beats from cycle skew.
    task automatic play_row(input string tag, input int skew, input int extra0, input fx_t xbeat);
        int ncyc;
        apply_q();
        ncyc = (extra0 > skew) ? NB + extra0 : NB + skew;
        for (int c = 0; c < ncyc; c++) begin
            in_valid[0] = (c < NB + extra0);
            in_force[0 +: W] = (c < NB) ? f[0][c] : xbeat;
            in_valid[1] = (c >= skew) && (c < skew + NB);
            in_force[W +: W] = (c >= skew && c < skew + NB) ? f[1][c - skew] : fx_t'(0);
            if (c == 0) chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
            cycle();
        end
        in_valid = '0;
        chk({tag, " valid T+1"}, 32'(out_valid), 32'd0);
        cycle();
        chk({tag, " valid T+2"}, 32'(out_valid), 32'd0);
        cycle();
        chk({tag, " valid T+3"}, 32'(out_valid), 32'd1);
        chk_outputs(tag);
        chk({tag, " step_done"}, 32'(out_step_done), 32'(out_ready && (row_m == NBR - 1)));
    endtask

    task automatic finish_hs(input string tag);
        out_ready = 1'b1;
        #1;
        chk({tag, " step_done hs"}, 32'(out_step_done), 32'(row_m == NBR - 1));
        cycle();
        row_m = (row_m + 1) % NBR;
        chk({tag, " valid after hs"}, 32'(out_valid), 32'd0);
        chk({tag, " ready after hs"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst = 1'b1; in_valid = '0; in_force = '0; out_ready = 1'b1;
        in_q_t = '0; in_q_told = '0; cfg_k = '0; row_m = 0;
        #1;
        chk("reset in_ready", 32'(in_ready), 32'd0);
        cycle(); cycle();
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset out_q_t", out_q_t[0 +: W], 32'd0);
        chk("reset out_row", 32'(out_row), 32'd0);
        chk("reset step_done", 32'(out_step_done), 32'd0);
        chk("reset err", 32'(dut.err_overrun_q), 32'd0);
        rst = 1'b0;
        #1;
        chk("post-reset in_ready", 32'(in_ready), 32'd1);

        // Basic update with hand-derived constants.
        f[0][0] = 32'h0001_0000; f[0][1] = 32'h0002_0000;
        f[1][0] = 32'h0000_8000; f[1][1] = 32'h0000_8000;
        qt[0] = 32'h0003_0000; qo[0] = 32'h0002_0000;
        qt[1] = 32'h0001_0000; qo[1] = 32'h0001_0000;
        kv = FX_ONE;
        play_row("basic", 0, 0, '0);
        chk("basic lane0 7.0", out_q_t[0 +: W], 32'h0007_0000);
        chk("basic lane1 2.0", out_q_t[W +: W], 32'h0002_0000);
        finish_hs("basic");

        // Same values, lane1 lagging by one cycle; this row is the last of the step.
        play_row("skew", 1, 0, '0);
        chk("skew lane0 7.0", out_q_t[0 +: W], 32'h0007_0000);
        finish_hs("skew");

        // Backpressure: outputs hold, in_ready low, stray beats ignored.
        rand_row(1'b0);
        out_ready = 1'b0;
        play_row("bp", 0, 0, '0);
        for (int i = 0; i < 5; i++) begin
            in_valid = '1;
            in_force = {$urandom, $urandom};
            cycle();
            chk("bp hold valid", 32'(out_valid), 32'd1);
            chk("bp in_ready", 32'(in_ready), 32'd0);
            chk_outputs("bp hold");
        end
        in_valid = '0;
        finish_hs("bp");
        chk("bp row now 1", 32'(out_row), 32'd1);
        chk("bp no overrun", 32'(dut.err_overrun_q), 32'd0);
        rand_row(1'b0);
        play_row("bp next", 1, 0, '0);
        finish_hs("bp next");
        chk("row wrapped", 32'(out_row), 32'd0);

        // Accumulator overflow: two 0x7FFF_0000 beats per lane.
        for (int r = 0; r < NR; r++) begin
            f[r][0] = 32'h7FFF_0000; f[r][1] = 32'h7FFF_0000;
            qt[r] = '0; qo[r] = '0;
        end
        kv = FX_ONE;
        play_row("ovf", 0, 0, '0);
`ifdef NBODY_SAT_EN
        chk("ovf sat", out_q_t[0 +: W], 32'h7FFF_FFFF);
`else
        chk("ovf wrap", out_q_t[0 +: W], 32'hFFFE_0000);
`endif
        finish_hs("ovf");

        // Reset after the first lane0 beat: nothing from that beat may survive.
        in_valid = 2'b01;
        in_force[0 +: W] = 32'h0123_4567;
        cycle();
        in_valid = '0;
        rst = 1'b1;
        #1;
        chk("rst in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("rst out_valid", 32'(out_valid), 32'd0);
        end
        rst = 1'b0;
        row_m = 0;
        #1;
        chk("rst release ready", 32'(in_ready), 32'd1);
        rand_row(1'b0);
        play_row("after rst", 0, 0, '0);
        finish_hs("after rst");

        // Third lane0 beat while lane1 still pending: dropped and flagged.
        rand_row(1'b0);
        play_row("extra", 2, 1, 32'h0055_0000);
        chk("extra err_overrun", 32'(dut.err_overrun_q), 32'd1);
        finish_hs("extra");

        // Random rows: random skew, value range and consumer stall.
        for (int n = 0; n < 8; n++) begin
            int stall;
            rand_row(n[0]);
            stall = $urandom_range(0, 3);
            out_ready = (stall == 0);
            play_row($sformatf("rnd%0d", n), $urandom_range(0, 2), 0, '0);
            for (int i = 0; i < stall; i++) cycle();
            if (stall > 0) chk_outputs($sformatf("rnd%0d stall", n));
            finish_hs($sformatf("rnd%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nbody_verlet_collector.md
Name: nbody_verlet_collector

Overview:
- Downstream of the systolic force array.
- Collects per-row force partial sums (right-edge outputs), which arrive skewed by one cycle per row.
- Accumulates them across all block-columns of a block-row, scales by G*dt^2, and performs the Verlet position update.
- Uses signed fixed point so it is synthesizable; it feeds updated positions back to the body-state store.

Parameters:
- N_ROWS, 2, systolic array dimension (lanes per block-row)
- N_BLOCKS, 2, block-columns accumulated per block-row
- N_BODY_ROWS, 2, block-rows per timestep (row index wraps here)
- W, 32, data width, signed two's complement
- FRAC, 16, fractional bits (1.0 = 0x0001_0000)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  N_ROWS  per-lane force beat valid
- in_force  in  N_ROWS*W  per-lane force partial sum, lane r at bits [r*W +: W]
- in_ready  out  1  collector accepting beats (common to all lanes)
- in_q_t  in  N_ROWS*W  current positions, sampled on leaving ACCUM
- in_q_told  in  N_ROWS*W  previous positions, sampled with in_q_t
- cfg_k  in  W  G*dt^2 in fixed point, sampled on leaving ACCUM
- out_valid  out  1  result valid
- out_ready  in  1  consumer ready
- out_q_t  out  N_ROWS*W  new positions
- out_q_told  out  N_ROWS*W  positions being retired (equal to sampled in_q_t)
- out_row  out  $clog2(N_BODY_ROWS)  block-row index of result
- out_step_done  out  1  pulses high with the last block-row's output handshake

Behaviour:
- Reset: all accumulators, lane counters, out_* and row index go to 0. in_ready=0 during reset and 1 on the first cycle after it. FSM=ACCUM.
- Reset mid-operation discards all partial state. No output is produced for the interrupted row.
- FSM: ACCUM -> MUL -> UPDATE -> HOLD -> ACCUM.
- ACCUM:
  - in_ready=1.
  - For each lane r with in_valid[r]: acc[r] += in_force[r] and cnt[r]++.
  - Lanes are independent, so skewed arrival is legal.
  - A beat on a lane whose cnt == N_BLOCKS is dropped and raises the sticky internal flag err_overrun. The flag is observable in the bench via hierarchy.
  - When every cnt == N_BLOCKS (including on the cycle the final beat lands), go to MUL next cycle. On that transition, sample in_q_t, in_q_told and cfg_k.
- MUL:
  - in_ready=0.
  - Compute prod[r] = (acc[r] * cfg_k) at 2W width, arithmetic shift right by FRAC (floor), truncate to W.
- UPDATE:
  - q_new = 2*q_t - q_told + prod, computed at W+2 bits and reduced to W (see Optional Feature).
  - Register out_q_t=q_new and out_q_told=q_t. Assert out_valid next cycle.
- HOLD:
  - out_valid=1. Outputs are stable until out_ready.
  - On handshake: clear acc and cnt, increment row (wrapping to 0 after N_BODY_ROWS-1), assert out_step_done for one cycle if row was N_BODY_ROWS-1, go to ACCUM.
- Latency: final lane beat in cycle T -> out_valid high in cycle T+3 when out_ready=1 throughout.
- Accumulation is W+$clog2(N_BLOCKS)+1 bits internally and reduced to W when entering MUL.
- Beats presented while in_ready=0 are ignored. They are not counted and raise no error.

Optional Feature:
- Macro NBODY_SAT_EN.
- Defined: every reduction to W bits (acc, prod, q_new) saturates to 0x7FFF_FFFF or 0x8000_0000.
- Undefined: reductions wrap (two's-complement truncation).

Decomposition:
- Package nbody_fx_pkg: typedef fx_t (logic signed [W-1:0]), FX_ONE, FX_MAX, FX_MIN, function fx_reduce (saturate or wrap under NBODY_SAT_EN), function fx_mul.
- One sub-module, nbody_verlet_lane: per-lane accumulator, counter, multiply and update. Instantiated N_ROWS times under a shared FSM in the top.

Test Plan:
- Basic update:
  - Stimulus: N_ROWS=2, N_BLOCKS=2, cfg_k=0x10000. Lane0 forces 1.0, 2.0; lane1 0.5, 0.5. Lane0 q_t=3.0, q_told=2.0; lane1 q_t=1.0, q_told=1.0.
  - Response: out_q_t = {7.0, 2.0}, out_q_told = {3.0, 1.0}, out_row=0, valid at T+3.
- Skewed arrival:
  - Stimulus: lane1 beats lag lane0 by one cycle; same values as the basic update.
  - Response: identical result, and out_valid is 3 cycles after the lane1 final beat.
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles.
  - Response: outputs stable, in_ready=0, new in_valid ignored. After release, row increments to 1. The next row's handshake pulses out_step_done and the row wraps to 0.
- Overflow:
  - Stimulus: forces 0x7FFF_0000 twice, cfg_k=0x10000.
  - Response: with NBODY_SAT_EN the acc saturates to 0x7FFF_FFFF. Without it, the result wraps to 0xFFFE_0000.
- Reset mid-row:
  - Stimulus: assert rst after the first lane0 beat.
  - Response: out_valid stays 0. After release, a full row yields results with no contribution from the pre-reset beat.
- Extra beat:
  - Stimulus: a third lane0 beat arrives while lane1 is still pending.
  - Response: the beat is dropped, err_overrun=1, and the result equals the two-beat sum.
